rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter REG_W, default 5, architectural index width (2**REG_W registers, x0 hardwired zero).
REQ-003 SHALL have parameter ROB_W, default 4, ROB position width.
REQ-004 SHALL have parameter RD_PORTS, default 2, number of combinational read ports.
REQ-005 SHALL have parameter CKPT_W, default 2, checkpoint index width (2**CKPT_W checkpoints).
REQ-006 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-007 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have rdy  in  1  global enable; when 0 no state changes except under rst.
REQ-009 SHALL have rd_idx  in  RD_PORTS*REG_W, rd_val  out  RD_PORTS*DATA_W, rd_busy  out  RD_PORTS, rd_tag  out  RD_PORTS*ROB_W  read ports, port k in slice k.
REQ-010 SHALL have issue  in  1, issue_rd  in  REG_W, issue_rob_pos  in  ROB_W  rename destination.
REQ-011 SHALL have commit  in  1, commit_rd  in  REG_W, commit_val  in  DATA_W, commit_rob_pos  in  ROB_W  ROB retire.
REQ-012 SHALL have ckpt_alloc  in  1, ckpt_id  out  CKPT_W, ckpt_full  out  1  snapshot allocation.
REQ-013 SHALL have ckpt_release  in  1  free oldest checkpoint (branch resolved correct).
REQ-014 SHALL have recover  in  1, recover_id  in  CKPT_W  restore map from checkpoint (mispredict).
REQ-015 SHALL have flush  in  1  full rollback: clear all busy flags, drop all checkpoints.

Function
REQ-016 Read: rd_busy/rd_tag from map[rd_idx]; rd_val from val[rd_idx]; x0 -> val 0, busy 0.
REQ-017 Bypass: commit && commit_rd!=0 && rd_idx==commit_rd && map busy with tag==commit_rob_pos -> rd_val=commit_val, rd_busy=0, same cycle.
REQ-018 Commit (commit_rd!=0): val[commit_rd]<=commit_val always; busy cleared only if tag matches commit_rob_pos.
REQ-019 Issue (issue_rd!=0): map[issue_rd]<={busy=1,tag=issue_rob_pos}; same-cycle commit to same rd: commit value written, issue tag wins.
REQ-020 Checkpoints form a circular queue: head (oldest), tail (next alloc), count 0..2**CKPT_W.
REQ-021 ckpt_id=tail; ckpt_full=(count==2**CKPT_W), combinational.
REQ-022 ckpt_alloc && !ckpt_full: snapshot[tail]<=next-state map (after same-cycle commit and issue); tail++; count++. Alloc when full ignored.
REQ-023 ckpt_release && count!=0: head++, count--. Release when empty ignored.
REQ-024 Every commit SHALL also clear busy in each live snapshot entry for commit_rd whose tag==commit_rob_pos.
REQ-025 recover: map<=snapshot[recover_id] with same-cycle commit clearing applied; same-cycle issue and alloc ignored; tail<=recover_id+1; count recomputed from post-release head.
REQ-026 recover_id outside live range: undefined, not checked.
REQ-027 Priority: rst > flush > recover > (commit, issue, alloc, release).
REQ-028 flush: all map busy<=0, head=tail=0, count=0; val unchanged; same-cycle commit value still written.
REQ-029 Pointer arithmetic modulo 2**CKPT_W, wrap-around with no gaps.

Reset
REQ-030 rst: all val<=0, all busy<=0, tags<=0, head=tail=count=0; after reset ckpt_full=0, ckpt_id=0, rd_busy=0, rd_val=0.
REQ-031 Snapshot contents need not be reset.

Configuration
REQ-032 Macro RENAME_CKPT_EN defined: checkpoint queue per REQ-020..REQ-029.
REQ-033 Macro RENAME_CKPT_EN undefined: no snapshot storage; ckpt_full=1, ckpt_id=0 constant; alloc/release ignored; recover behaves as flush.

Verification
REQ-034 Issue x5 tag 3; next cycle commit x5 tag 3 val 0x1234 with rd_idx=5 -> same-cycle rd_val=0x1234, rd_busy=0; thereafter busy 0.
REQ-035 Issue x5 tag 3, then issue x5 tag 7, commit x5 tag 3 -> val[5] updated, rd_busy=1, rd_tag=7.
REQ-036 Issue x1 tag 2, alloc (id 0), issue x1 tag 4, commit tag 2, recover 0 -> x1 busy 0, val=committed value; tail=1.
REQ-037 Alloc 4 times -> ckpt_full=1; 5th alloc ignored; release 1 -> ckpt_full=0, ckpt_id=0 (wrapped).
REQ-038 Alloc ids 0,1,2; recover 1 -> map equals snapshot 1, ckpt_id=2, count 2.
REQ-039 Issue x0 tag 1, commit x0 val 0xFF -> rd_val 0, rd_busy 0 for rd_idx=0.

Source files
------------

// File: rtl/rename_regfile.sv
// rename_regfile: register file plus rename map with optional branch checkpoint queue.
// Define RENAME_CKPT_EN to build the snapshot queue; otherwise recover acts as a flush.
module rename_regfile #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int ROB_W    = 4,
    parameter int RD_PORTS = 2,
    parameter int CKPT_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [RD_PORTS*REG_W-1:0]    rd_idx,
    output logic [RD_PORTS*DATA_W-1:0]   rd_val,
    output logic [RD_PORTS-1:0]          rd_busy,
    output logic [RD_PORTS*ROB_W-1:0]    rd_tag,
    input  logic                         issue,
    input  logic [REG_W-1:0]             issue_rd,
    input  logic [ROB_W-1:0]             issue_rob_pos,
    input  logic                         commit,
    input  logic [REG_W-1:0]             commit_rd,
    input  logic [DATA_W-1:0]            commit_val,
    input  logic [ROB_W-1:0]             commit_rob_pos,
    input  logic                         ckpt_alloc,
    output logic [CKPT_W-1:0]            ckpt_id,
    output logic                         ckpt_full,
    input  logic                         ckpt_release,
    input  logic                         recover,
    input  logic [CKPT_W-1:0]            recover_id,
    input  logic                         flush
);
    localparam int NR = 1 << REG_W;

    logic [DATA_W-1:0] val [NR];
    logic [NR-1:0]     busy;
    logic [ROB_W-1:0]  tag [NR];
    logic [NR-1:0]     busy_nx;
    logic [ROB_W-1:0]  tag_nx [NR];
    logic [NR-1:0]     rec_busy;
    logic [ROB_W-1:0]  rec_tag [NR];
    logic              cm, is, cm_hit, wipe;

    assign cm     = commit && commit_rd != '0;
    assign is     = issue && issue_rd != '0;
    assign cm_hit = cm && busy[commit_rd] && tag[commit_rd] == commit_rob_pos;

    // Next-state map: commit clears first, then a same-cycle issue takes the entry.
    always_comb begin
        busy_nx = busy;
        tag_nx  = tag;
        if (cm_hit) busy_nx[commit_rd] = 1'b0;
        if (is) begin
            busy_nx[issue_rd] = 1'b1;
            tag_nx[issue_rd]  = issue_rob_pos;
        end
    end

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
        logic [REG_W-1:0] idx;
        logic             byp;
        assign idx = rd_idx[g*REG_W +: REG_W];
        assign byp = cm_hit && idx == commit_rd;
        assign rd_val[g*DATA_W +: DATA_W] = idx == '0 ? '0 : byp ? commit_val : val[idx];
        assign rd_busy[g] = idx != '0 && busy[idx] && !byp;
        assign rd_tag[g*ROB_W +: ROB_W] = tag[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NR; r++) val[r] <= '0;
        end else if (rdy && cm) begin
            val[commit_rd] <= commit_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int r = 0; r < NR; r++) tag[r] <= '0;
        end else if (rdy) begin
            if (wipe) begin
                busy <= '0;
            end else if (recover) begin
                busy <= rec_busy;
                tag  <= rec_tag;
            end else begin
                busy <= busy_nx;
                tag  <= tag_nx;
            end
        end
    end

`ifdef RENAME_CKPT_EN
    localparam int NC = 1 << CKPT_W;

    logic [NR-1:0]     snap_busy [NC];
    logic [ROB_W-1:0]  snap_tag [NC][NR];
    logic [CKPT_W-1:0] head, tail, head_rel, rec_dist;
    logic [CKPT_W:0]   count;
    logic              do_alloc, do_rel;

    assign wipe      = flush;
    assign ckpt_id   = tail;
    assign ckpt_full = count == (CKPT_W+1)'(NC);
    assign do_alloc  = ckpt_alloc && !ckpt_full && !recover && !flush;
    assign do_rel    = ckpt_release && count != '0;
    assign head_rel  = head + CKPT_W'(do_rel);
    assign rec_dist  = recover_id - head_rel;
    assign rec_tag   = snap_tag[recover_id];

    // The restored map must reflect a retire landing in the same cycle.
    always_comb begin
        rec_busy = snap_busy[recover_id];
        if (cm && snap_tag[recover_id][commit_rd] == commit_rob_pos) rec_busy[commit_rd] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (recover) begin
                head  <= head_rel;
                tail  <= recover_id + CKPT_W'(1);
                count <= {1'b0, rec_dist} + (CKPT_W+1)'(1);
            end else begin
                head  <= head_rel;
                tail  <= tail + CKPT_W'(do_alloc);
                count <= count + (CKPT_W+1)'(do_alloc) - (CKPT_W+1)'(do_rel);
            end
        end
    end

    // Dead slots are cleared too; harmless since allocation overwrites them whole.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush) begin
            for (int c = 0; c < NC; c++)
                if (cm && snap_tag[c][commit_rd] == commit_rob_pos) snap_busy[c][commit_rd] <= 1'b0;
            if (do_alloc) begin
                snap_busy[tail] <= busy_nx;
                snap_tag[tail]  <= tag_nx;
            end
        end
    end
`else
    logic unused_ckpt;

    assign wipe        = flush || recover;
    assign ckpt_id     = '0;
    assign ckpt_full   = 1'b1;
    assign rec_busy    = '0;
    assign rec_tag     = tag;
    assign unused_ckpt = ^{ckpt_alloc, ckpt_release, recover_id};
`endif

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed and random checks of rename_regfile against a queue-based model.
// Checkpoint scenarios are exercised only when RENAME_CKPT_EN is defined.
module tb_rename_regfile;
    localparam int DW = 32, RW = 5, BW = 4, RP = 2, CW = 2, NR = 32, NC = 4;
`ifdef RENAME_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [NR-1:0]    b;
        logic [NR*BW-1:0] t;
    } snap_t;

    logic clk = 1'b0, rst, rdy;
    logic [RP*RW-1:0] rd_idx;
    logic [RP*DW-1:0] rd_val;
    logic [RP-1:0]    rd_busy;
    logic [RP*BW-1:0] rd_tag;
    logic issue, commit, ckpt_alloc, ckpt_full, ckpt_release, recover, flush;
    logic [RW-1:0] issue_rd, commit_rd;
    logic [BW-1:0] issue_rob_pos, commit_rob_pos;
    logic [DW-1:0] commit_val;
    logic [CW-1:0] ckpt_id, recover_id;

    logic [DW-1:0] m_val [NR];
    snap_t m_map;
    snap_t ckq[$];
    int base;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rename_regfile #(.DATA_W(DW), .REG_W(RW), .ROB_W(BW), .RD_PORTS(RP), .CKPT_W(CW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy),
        .rd_tag(rd_tag), .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos), .ckpt_alloc(ckpt_alloc), .ckpt_id(ckpt_id),
        .ckpt_full(ckpt_full), .ckpt_release(ckpt_release), .recover(recover),
        .recover_id(recover_id), .flush(flush)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    function automatic snap_t retire(input snap_t s);
        if (commit && commit_rd != 0 && s.t[commit_rd*BW +: BW] == commit_rob_pos) s.b[commit_rd] = 1'b0;
        return s;
    endfunction

    task automatic check_all();
        logic [RW-1:0] idx;
        logic [DW-1:0] ev;
        logic          eb;
        logic [BW-1:0] et;
        for (int p = 0; p < RP; p++) begin
            idx = rd_idx[p*RW +: RW];
            et  = m_map.t[idx*BW +: BW];
            eb  = idx != 0 && m_map.b[idx];
            ev  = idx == 0 ? '0 : m_val[idx];
            if (commit && commit_rd != 0 && idx == commit_rd && eb && et == commit_rob_pos) begin
                ev = commit_val;
                eb = 1'b0;
            end
            chk("rd_val", 64'(rd_val[p*DW +: DW]), 64'(ev));
            chk("rd_busy", 64'(rd_busy[p]), 64'(eb));
            chk("rd_tag", 64'(rd_tag[p*BW +: BW]), 64'(et));
        end
        chk("ckpt_id", 64'(ckpt_id), CK ? 64'((base + ckq.size()) % NC) : 64'd0);
        chk("ckpt_full", 64'(ckpt_full), CK ? 64'(ckq.size() == NC) : 64'd1);
    endtask

    task automatic model_edge();
        snap_t nm;
        int    i;
        bit    a_ok, r_ok;
        if (rst) begin
            for (int r = 0; r < NR; r++) m_val[r] = '0;
            m_map = '0;
            ckq.delete();
            base = 0;
            return;
        end
        if (!rdy) return;
        if (commit && commit_rd != 0) m_val[commit_rd] = commit_val;
        for (int k = 0; k < ckq.size(); k++) ckq[k] = retire(ckq[k]);
        if (flush || (recover && !CK)) begin
            m_map.b = '0;
            ckq.delete();
            base = 0;
        end else if (recover) begin
            i = (int'(recover_id) - base) & (NC - 1);
            while (ckq.size() > i + 1) void'(ckq.pop_back());
            m_map = ckq[i];
        end else begin
            nm = retire(m_map);
            if (issue && issue_rd != 0) begin
                nm.b[issue_rd] = 1'b1;
                nm.t[issue_rd*BW +: BW] = issue_rob_pos;
            end
            a_ok = CK && ckpt_alloc && ckq.size() < NC;
            r_ok = CK && ckpt_release && ckq.size() > 0;
            if (r_ok) begin
                void'(ckq.pop_front());
                base = (base + 1) % NC;
            end
            if (a_ok) ckq.push_back(nm);
            m_map = nm;
        end
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; issue = 0; commit = 0; ckpt_alloc = 0; ckpt_release = 0;
        recover = 0; flush = 0; recover_id = '0;
    endtask

    task automatic do_issue(input logic [RW-1:0] r, input logic [BW-1:0] t);
        issue = 1; issue_rd = r; issue_rob_pos = t;
    endtask

    task automatic do_commit(input logic [RW-1:0] r, input logic [BW-1:0] t, input logic [DW-1:0] v);
        commit = 1; commit_rd = r; commit_rob_pos = t; commit_val = v;
    endtask

    initial begin
        int off;
        idle();
        issue_rd = '0; issue_rob_pos = '0; commit_rd = '0; commit_rob_pos = '0; commit_val = '0;
        rd_idx = {5'd1, 5'd5};
        rst = 1;
        @(negedge clk);
        tick(); tick();
        idle();
        #1;
        chk("rst_val", 64'(rd_val), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_id", 64'(ckpt_id), 64'd0);
        chk("rst_full", 64'(ckpt_full), CK ? 64'd0 : 64'd1);

        do_issue(5, 3); tick(); idle();
        do_commit(5, 3, 32'h1234);
        #1;
        chk("byp_val", 64'(rd_val[31:0]), 64'h1234);
        chk("byp_busy", 64'(rd_busy[0]), 64'd0);
        tick(); idle();
        #1;
        chk("post_busy", 64'(rd_busy[0]), 64'd0);
        chk("post_val", 64'(rd_val[31:0]), 64'h1234);

        do_issue(5, 3); tick(); idle();
        do_issue(5, 7); tick(); idle();
        do_commit(5, 3, 32'hBEEF); tick(); idle();
        #1;
        chk("stale_val", 64'(rd_val[31:0]), 64'hBEEF);
        chk("stale_busy", 64'(rd_busy[0]), 64'd1);
        chk("stale_tag", 64'(rd_tag[3:0]), 64'd7);

        do_issue(0, 1); tick(); idle();
        rd_idx = {5'd5, 5'd0};
        do_commit(0, 1, 32'hFF);
        #1;
        chk("x0_val", 64'(rd_val[31:0]), 64'd0);
        chk("x0_busy", 64'(rd_busy[0]), 64'd0);
        tick(); idle();
        #1;
        chk("x0_val2", 64'(rd_val[31:0]), 64'd0);
        chk("x0_busy2", 64'(rd_busy[0]), 64'd0);

`ifdef RENAME_CKPT_EN
        flush = 1; tick(); idle();
        rd_idx = {5'd0, 5'd1};
        do_issue(1, 2); tick(); idle();
        ckpt_alloc = 1;
        #1 chk("alloc_id0", 64'(ckpt_id), 64'd0);
        tick(); idle();
        do_issue(1, 4); tick(); idle();
        do_commit(1, 2, 32'h55); tick(); idle();
        recover = 1; recover_id = 0; tick(); idle();
        #1;
        chk("rec_busy", 64'(rd_busy[0]), 64'd0);
        chk("rec_val", 64'(rd_val[31:0]), 64'h55);
        chk("rec_tail", 64'(ckpt_id), 64'd1);

        flush = 1; tick(); idle();
        ckpt_alloc = 1;
        repeat (4) tick();
        #1;
        chk("full4", 64'(ckpt_full), 64'd1);
        chk("full4_id", 64'(ckpt_id), 64'd0);
        tick();
        #1;
        chk("full5", 64'(ckpt_full), 64'd1);
        chk("full5_id", 64'(ckpt_id), 64'd0);
        idle(); ckpt_release = 1; tick(); idle();
        #1;
        chk("rel_full", 64'(ckpt_full), 64'd0);
        chk("rel_id", 64'(ckpt_id), 64'd0);

        flush = 1; tick(); idle();
        rd_idx = {5'd4, 5'd3};
        ckpt_alloc = 1;
        do_issue(2, 1); tick();
        do_issue(3, 2); tick();
        do_issue(4, 3); tick(); idle();
        recover = 1; recover_id = 1; tick(); idle();
        #1;
        chk("r1_id", 64'(ckpt_id), 64'd2);
        chk("r1_full", 64'(ckpt_full), 64'd0);
        chk("r1_x3busy", 64'(rd_busy[0]), 64'd1);
        chk("r1_x3tag", 64'(rd_tag[3:0]), 64'd2);
        chk("r1_x4busy", 64'(rd_busy[1]), 64'd0);
        ckpt_alloc = 1; tick();
        #1 chk("r1_cnt3", 64'(ckpt_full), 64'd0);
        tick();
        #1 chk("r1_cnt4", 64'(ckpt_full), 64'd1);
        idle(); flush = 1; tick(); idle();
`endif

        repeat (400) begin
            idle();
            rst = ($urandom % 200) == 0;
            rdy = ($urandom % 10) != 0;
            issue = 1'($urandom % 2);
            issue_rd = RW'($urandom);
            issue_rob_pos = BW'($urandom);
            commit = rdy && ($urandom % 2) == 1;
            commit_rd = RW'($urandom);
            commit_rob_pos = ($urandom % 10 < 7) ? m_map.t[commit_rd*BW +: BW] : BW'($urandom);
            commit_val = $urandom;
            flush = ($urandom % 40) == 0;
`ifdef RENAME_CKPT_EN
            if (ckq.size() > 0 && ($urandom % 25) == 0) begin
                off = int'($urandom % ckq.size());
                recover = 1;
                recover_id = CW'(base + off);
            end
`else
            recover = ($urandom % 25) == 0;
            recover_id = CW'($urandom);
`endif
            ckpt_alloc = ($urandom % 10) < 3;
            ckpt_release = !recover && ($urandom % 5) == 0;
            rd_idx = RP*RW'($urandom);
            if (($urandom % 3) == 0) rd_idx[RW-1:0] = commit_rd;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
